// File: rtl/conv_mac_engine_pkg.sv
// Shared types and width helpers for the convolution MAC engine.
package conv_mac_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-precision sum width: product width plus growth for K*K terms.
    function automatic int unsigned acc_width(input int unsigned bits, input int unsigned k);
        return 2 * bits + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_weight_rf.sv
// K*K signed weight register file: synchronous write, combinational read.
module conv_weight_rf #(
    parameter int unsigned BITS  = 9,
    parameter int unsigned DEPTH = 9,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [BITS-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [BITS-1:0] rdata
);

    logic [BITS-1:0] mem [DEPTH];

    // Out-of-range addresses are dropped rather than aliased.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_mac_engine.sv
// One convolution output pixel per accepted KxK window, using a single
// shared signed multiplier over K*K MAC cycles.
module conv_mac_engine
    import conv_mac_engine_pkg::*;
#(
    parameter int unsigned BITS        = 9,
    parameter int unsigned KERNEL_SIZE = 3,
    localparam int unsigned NUM        = KERNEL_SIZE * KERNEL_SIZE,
    localparam int unsigned AW         = $clog2(NUM),
    localparam int unsigned ACC_BITS   = acc_width(BITS, KERNEL_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  weight_we,
    input  logic [AW-1:0]         weight_addr,
    input  logic [BITS-1:0]       weight_data,
    input  logic                  window_valid,
    input  logic [NUM*BITS-1:0]   window,
    output logic                  window_ready,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic [ACC_BITS-1:0]   pixel_out,
    output logic                  busy
);

    localparam int unsigned PROD_BITS = 2 * BITS;

    state_t                      state;
    logic [AW-1:0]               idx;
    logic signed [ACC_BITS-1:0]  acc;
    logic [NUM*BITS-1:0]         win_q;

    logic                        rf_we_c;
    logic signed [BITS-1:0]      w_c;
    logic signed [BITS-1:0]      x_c;
    logic signed [PROD_BITS-1:0] prod_c;
    logic signed [ACC_BITS-1:0]  sum_c;

    // Weights are frozen while a window is in flight.
    assign rf_we_c = weight_we && !busy;

    conv_weight_rf #(
        .BITS  (BITS),
        .DEPTH (NUM)
    ) u_weight_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (rf_we_c),
        .waddr   (weight_addr),
        .wdata   (weight_data),
        .raddr   (idx),
        .rdata   (w_c)
    );

    assign x_c    = win_q[BITS*32'(idx) +: BITS];
    assign prod_c = w_c * x_c;
    assign sum_c  = acc + ACC_BITS'(prod_c);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= '0;
            win_q        <= '0;
            pixel_valid  <= 1'b0;
            pixel_out    <= '0;
            busy         <= 1'b0;
            window_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (window_valid) begin
                        win_q        <= window;
                        acc          <= '0;
                        idx          <= '0;
                        state        <= MAC;
                        window_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= sum_c;
                    idx <= idx + AW'(1);
                    // Last term: publish the completed sum directly.
                    if (idx == AW'(NUM - 1)) begin
                        state       <= DONE;
                        pixel_valid <= 1'b1;
                        pixel_out   <= sum_c;
                    end
                end
                DONE: begin
                    if (pixel_ready) begin
                        state        <= IDLE;
                        pixel_valid  <= 1'b0;
                        busy         <= 1'b0;
                        window_ready <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    pixel_valid  <= 1'b0;
                    busy         <= 1'b0;
                    window_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: vector table plus backpressure and reset corner cases.
module tb_conv_mac_engine;

    localparam int BITS = 9;
    localparam int K    = 3;
    localparam int NUM  = 9;
    localparam int AW   = 4;
    localparam int ACCW = 22;

    typedef int arr9_t [9];

    typedef struct {
        logic [NUM*BITS-1:0] w;
        logic [NUM*BITS-1:0] px;
        int                  exp_out;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                weight_we = 1'b0;
    logic [AW-1:0]       weight_addr = '0;
    logic [BITS-1:0]     weight_data = '0;
    logic                window_valid = 1'b0;
    logic [NUM*BITS-1:0] window = '0;
    logic                window_ready;
    logic                pixel_valid;
    logic                pixel_ready = 1'b1;
    logic [ACCW-1:0]     pixel_out;
    logic                busy;

    int checks = 0;
    int failures = 0;

    conv_mac_engine #(
        .BITS        (BITS),
        .KERNEL_SIZE (K)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .weight_we    (weight_we),
        .weight_addr  (weight_addr),
        .weight_data  (weight_data),
        .window_valid (window_valid),
        .window       (window),
        .window_ready (window_ready),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .pixel_out    (pixel_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM*BITS-1:0] pack9(input arr9_t a);
        logic [NUM*BITS-1:0] v;
        v = '0;
        for (int j = 0; j < NUM; j++) v[BITS*j +: BITS] = BITS'(a[j]);
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int j, input int v);
        weight_we   = 1'b1;
        weight_addr = AW'(j);
        weight_data = BITS'(v);
        tick();
        weight_we   = 1'b0;
    endtask

    task automatic load_weights(input logic [NUM*BITS-1:0] w);
        for (int j = 0; j < NUM; j++) write_w(j, int'($signed(w[BITS*j +: BITS])));
    endtask

    // Offer one window, scramble the input afterwards, and wait for the result.
    task automatic run_window(input logic [NUM*BITS-1:0] px, output int res, output int lat);
        int n;
        window       = px;
        window_valid = 1'b1;
        tick();
        window_valid = 1'b0;
        window       = {$urandom, $urandom, $urandom};
        n = 0;
        while (!pixel_valid && n < 50) begin
            tick();
            n++;
        end
        lat = n + 1;
        res = int'($signed(pixel_out));
    endtask

    vec_t vecs [6];

    initial begin
        int res;
        int lat;
        logic [NUM*BITS-1:0] pat;

        pat = pack9('{0, 1, 2, 16, 17, 18, 32, 33, 34});
        vecs[0] = '{pack9('{1, 1, 1, 1, 1, 1, 1, 1, 1}), pat, 153};
        vecs[1] = '{pack9('{0, 0, 0, 0, 1, 0, 0, 0, 0}), pat, 17};
        vecs[2] = '{pack9('{0, 0, 0, 0, -1, 0, 0, 0, 0}), pat, -17};
        vecs[3] = '{pack9('{-256, -256, -256, -256, -256, -256, -256, -256, -256}),
                    pack9('{-256, -256, -256, -256, -256, -256, -256, -256, -256}), 589824};
        vecs[4] = '{pack9('{255, 255, 255, 255, 255, 255, 255, 255, 255}),
                    pack9('{-256, -256, -256, -256, -256, -256, -256, -256, -256}), -587520};
        vecs[5] = '{pack9('{1, -1, 2, -2, 3, -3, 4, -4, 5}),
                    pack9('{10, 20, 30, 40, 50, 60, 70, 80, 90}), 350};

        // Reset state
        repeat (2) tick();
        check("reset pixel_valid", int'(pixel_valid), 0);
        check("reset pixel_out", int'(pixel_out), 0);
        check("reset window_ready", int'(window_ready), 1);
        check("reset busy", int'(busy), 0);
        reset_n = 1'b1;
        tick();
        check("post-reset window_ready", int'(window_ready), 1);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            load_weights(vecs[i].w);
            run_window(vecs[i].px, res, lat);
            check($sformatf("vec%0d pixel_out", i), res, vecs[i].exp_out);
            check($sformatf("vec%0d latency", i), lat, 10);
            tick();
            check($sformatf("vec%0d back to idle", i), int'(window_ready), 1);
        end

        // Backpressure hold with a dropped weight write
        load_weights(vecs[0].w);
        write_w(9, 7);
        pixel_ready = 1'b0;
        run_window(pat, res, lat);
        check("bp pixel_out", res, 153);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                weight_we = 1'b1; weight_addr = 4'd0; weight_data = 9'd100;
            end
            tick();
            weight_we = 1'b0;
            check($sformatf("bp hold%0d pixel_valid", c), int'(pixel_valid), 1);
            check($sformatf("bp hold%0d pixel_out", c), int'($signed(pixel_out)), 153);
            check($sformatf("bp hold%0d window_ready", c), int'(window_ready), 0);
        end
        pixel_ready = 1'b1;
        tick();
        check("bp release pixel_valid", int'(pixel_valid), 0);
        run_window(pat, res, lat);
        check("bp weights unchanged", res, 153);
        tick();

        // Reset mid-MAC at idx=4
        window       = pat;
        window_valid = 1'b1;
        tick();
        window_valid = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("midreset pixel_valid", int'(pixel_valid), 0);
        check("midreset busy", int'(busy), 0);
        tick();
        reset_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 15; c++) begin
                tick();
                if (pixel_valid) seen++;
            end
            check("midreset no stale pixel", seen, 0);
        end
        run_window(pat, res, lat);
        check("midreset weights cleared", res, 0);
        check("midreset latency", lat, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
